// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and opcode encodings for the logic unit
// and the result mux that reuses it.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
    localparam logic [OP_W-1:0] OP_AND  = 3'd1;
    localparam logic [OP_W-1:0] OP_OR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/nbit_logic_func.sv
// Stateless bitwise logic function selected by opcode; NOT and PASS use only in1.
module nbit_logic_func
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (op)
            OP_NOT:  res = ~in1;
            OP_AND:  res = in1 & in2;
            OP_OR:   res = in1 | in2;
            OP_NAND: res = ~(in1 & in2);
            OP_NOR:  res = ~(in1 | in2);
            OP_XOR:  res = in1 ^ in2;
            OP_XNOR: res = ~(in1 ^ in2);
            OP_PASS: res = in1;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/nbit_logic_pipe.sv
// Two-stage valid/ready logic unit: S1 holds operands, S2 holds the result with
// its zero/parity flags; also keeps a saturating count of delivered results.
module nbit_logic_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      op,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 zero,
    output logic                 parity,
    output logic [CNT_WIDTH-1:0] count
);

    logic                 s1_valid_reg;
    logic [OP_W-1:0]      s1_op_reg;
    logic [WIDTH-1:0]     s1_in1_reg;
    logic [WIDTH-1:0]     s1_in2_reg;
    logic                 s2_valid_reg;
    logic [WIDTH-1:0]     out_reg;
    logic                 zero_reg;
    logic                 parity_reg;
    logic [CNT_WIDTH-1:0] count_reg;

    logic             adv2;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] func_res;

    // S2 can take the S1 beat when it is empty or draining this cycle.
    assign adv2     = s1_valid_reg && (!s2_valid_reg || out_ready);
    assign in_ready = !s1_valid_reg || adv2;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid_reg && out_ready;

    nbit_logic_func #(
        .WIDTH (WIDTH)
    ) u_func (
        .op  (s1_op_reg),
        .in1 (s1_in1_reg),
        .in2 (s1_in2_reg),
        .res (func_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= '0;
            s1_in1_reg   <= '0;
            s1_in2_reg   <= '0;
        end else if (in_xfer) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= op;
            s1_in1_reg   <= in1;
            s1_in2_reg   <= in2;
        end else if (adv2) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Result and flags load together so the flags always describe out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            out_reg      <= '0;
            zero_reg     <= 1'b1;
            parity_reg   <= 1'b0;
        end else if (adv2) begin
            s2_valid_reg <= 1'b1;
            out_reg      <= func_res;
            zero_reg     <= (func_res == '0);
            parity_reg   <= ^func_res;
        end else if (out_xfer) begin
            s2_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (out_xfer && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out       = out_reg;
    assign zero      = zero_reg;
    assign parity    = parity_reg;
    assign count     = count_reg;

endmodule

// File: doc/nbit_logic_pipe.md
Name: nbit_logic_pipe

Overview:
- Registered, parametrised n-bit logic unit with an opcode select: NOT, AND, OR, NAND, NOR, XOR, XNOR, PASS.
- Two-stage pipeline with valid/ready handshakes on input and output, full throughput, and backpressure.
- Produces zero and parity flags plus a saturating count of delivered results.
- Sits between the operand sequencer and the ALU result mux; replaces the stateless per-gate n-bit modules.

Parameters:
- WIDTH, 4: operand/result width in bits (>=1).
- CNT_WIDTH, 16: width of the delivered-result counter (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- op  in  3  opcode: 0 NOT in1, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS in1.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B (ignored for ops 0 and 7).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out  out  WIDTH  result.
- zero  out  1  out == 0.
- parity  out  1  XOR-reduction of out.
- count  out  CNT_WIDTH  number of results accepted downstream; saturating.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - s1_valid = s2_valid = 0; out = 0; zero = 1; parity = 0; count = 0.
  - Stage data registers clear to 0.
  - Asserting rst mid-operation discards all in-flight beats; nothing is replayed after reset.
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Stage 1 (S1) captures op, in1, in2 on an input transfer.
- Stage 2 (S2) computes the opcode function on the S1 contents and registers out, zero and parity together.
  - zero and parity always describe the registered out.
  - out_valid = s2_valid.
- Advance rules:
  - adv2 = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || adv2. This is a combinational path from out_ready; that path is accepted.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+1. Minimum 2 cycles input-to-output transfer.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure:
  - While out_valid && !out_ready, out, zero and parity hold stable.
  - S1 can hold one more beat, so at most 2 beats are in flight. in_ready drops only when both stages are full and out_ready=0.
- Simultaneous events:
  - Input and output transfers in the same cycle with both stages full: all stages shift, no beat is lost or duplicated.
  - When S2 empties with no new S1 beat, s2_valid clears. out keeps its last value; it is not defined as valid.
- Counter:
  - count increments by 1 on each output transfer.
  - At all-ones it holds; it does not wrap.
- Widths:
  - All logic ops are bitwise on WIDTH bits.
  - NOT and PASS use only in1.
  - No carry or overflow; there is no arithmetic in this block.
- Protocol:
  - in_valid need not be held by the source while in_ready=0; the block samples only on a transfer.
  - out_valid, once high, stays high until the output transfer.

Decomposition:
- Shared package `alu_pkg` holds:
  - opcode constants OP_NOT=0, OP_AND=1, OP_OR=2, OP_NAND=3, OP_NOR=4, OP_XOR=5, OP_XNOR=6, OP_PASS=7.
  - opcode width constant OP_W=3.
- One combinational sub-module `nbit_logic_func` (WIDTH param: op, in1, in2 -> res) for S2 compute; reusable by the ALU mux.
- Pipeline control and the counter live in the top.

Test Plan:
- WIDTH=4, reset mid-stream with 2 beats in flight -> out_valid=0, in_ready=1, count=0, zero=1 immediately; no result appears after release.
- Exhaustive sweep, all 8 ops x 16 x 16 operands, out_ready=1, in_valid every cycle -> one result per cycle, 2-cycle latency. Spot checks:
  - op=1, in1=0xC, in2=0xA -> out=0x8.
  - op=6, 0xC/0xA -> out=0x9, parity=0.
  - op=0, in1=0x0 -> out=0xF, parity=0.
  - op=3, 0xF/0xF -> out=0x0, zero=1.
- Backpressure: send beats A, B, C with out_ready=0 -> in_ready=0 after A and B are held. out stays at A's result until out_ready=1, then A, B, C emerge in order with no loss.
- Simultaneous transfers: both stages full, in_valid=1, out_ready=1 for 5 cycles -> 5 results out, 5 accepted, in_ready stays 1.
- Counter saturation: CNT_WIDTH=3, 10 output transfers -> count reaches 7 and holds at 7.
- PASS/NOT ignore in2: op=7, in1=0x5, in2 random -> out=0x5 every beat, parity=0.
